// File: rtl/fp_sort_ctrl_if.sv
// Stream bundle for fp_sort_ctrl.
// Input side: in_valid/in_ready/in_data plus the per-block sort order (desc).
// Output side: out_valid/out_ready/out_data/out_last.
// The slave modport is the sorter; the master modport is the surrounding environment.
interface fp_sort_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        desc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output in_valid, in_data, desc, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, desc, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fp_sort_ctrl.sv
// Block sorter for IEEE 754 single-precision words using a single shared comparator.
// LOAD streams DEPTH words into a buffer, SORT runs (DEPTH-1) full bubble passes with one
// compare-and-swap per cycle, OUT streams the ordered block back out.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset, aborts any block in flight
//   bus      - slave side of fp_sort_ctrl_if (input stream, desc, output stream)
//   busy     - high while sorting or streaming out
//   swap_cnt - swaps performed in the current/last block, saturating
module fp_sort_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_sort_ctrl_if.slave bus,
    output logic          busy,
    output logic [CW-1:0] swap_cnt
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LastIdx  = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LastPair = IW'(DEPTH - 2);

    // StPresent is the tail of the sort phase: it loads the first output word once the
    // buffer has settled after the final compare-and-swap.
    typedef enum logic [1:0] {
        StLoad,
        StSort,
        StPresent,
        StOut
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   pass_q, pass_d;
    logic [IW-1:0]   pair_q, pair_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            desc_q, desc_d;
    logic [CW-1:0]   swap_cnt_q, swap_cnt_d;
    logic [31:0]     buf_q [DEPTH];

    logic            in_fire;
    logic            do_swap;
    logic [31:0]     cmp_lo;
    logic [31:0]     cmp_hi;

    // Total order on raw bit patterns: sign first, then magnitude (reversed when negative).
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        logic r;
        if (a[31] != b[31]) begin
            r = ~a[31];
        end else if (!a[31]) begin
            r = a[30:0] > b[30:0];
        end else begin
            r = a[30:0] < b[30:0];
        end
        return r;
    endfunction

    assign cmp_lo  = buf_q[pair_q];
    assign cmp_hi  = buf_q[pair_q + IW'(1)];
    assign in_fire = (state_q == StLoad) && in_ready_q && bus.in_valid;
    // Strict comparison in both orders keeps equal keys in place.
    assign do_swap = (state_q == StSort) &&
                     (desc_q ? fp_gt(cmp_hi, cmp_lo) : fp_gt(cmp_lo, cmp_hi));

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        pass_d      = pass_q;
        pair_d      = pair_q;
        rd_idx_d    = rd_idx_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        desc_d      = desc_q;
        swap_cnt_d  = swap_cnt_q;

        case (state_q)
            StLoad: begin
                // Also raises in_ready on the first edge after reset release.
                in_ready_d = 1'b1;
                if (in_fire) begin
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_q == '0) begin
                        desc_d     = bus.desc;
                        swap_cnt_d = '0;
                    end
                    if (wr_idx_q == LastIdx) begin
                        wr_idx_d   = '0;
                        in_ready_d = 1'b0;
                        state_d    = StSort;
                    end
                end
            end
            StSort: begin
                if (do_swap && (swap_cnt_q != {CW{1'b1}})) begin
                    swap_cnt_d = swap_cnt_q + CW'(1);
                end
                if (pair_q == LastPair) begin
                    pair_d = '0;
                    if (pass_q == LastPair) begin
                        pass_d  = '0;
                        state_d = StPresent;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    pair_d = pair_q + IW'(1);
                end
            end
            StPresent: begin
                state_d     = StOut;
                out_valid_d = 1'b1;
                out_data_d  = buf_q[0];
                out_last_d  = 1'b0;
                rd_idx_d    = '0;
            end
            StOut: begin
                if (out_valid_q && bus.out_ready) begin
                    if (rd_idx_q == LastIdx) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        rd_idx_d    = '0;
                        in_ready_d  = 1'b1;
                        state_d     = StLoad;
                    end else begin
                        rd_idx_d   = rd_idx_q + IW'(1);
                        out_data_d = buf_q[rd_idx_q + IW'(1)];
                        out_last_d = (rd_idx_q + IW'(1)) == LastIdx;
                    end
                end
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StLoad;
            wr_idx_q    <= '0;
            pass_q      <= '0;
            pair_q      <= '0;
            rd_idx_q    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            desc_q      <= 1'b0;
            swap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            pass_q      <= pass_d;
            pair_q      <= pair_d;
            rd_idx_q    <= rd_idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            desc_q      <= desc_d;
            swap_cnt_q  <= swap_cnt_d;
        end
    end

    // Buffer contents are meaningless after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[wr_idx_q] <= bus.in_data;
        end else if (do_swap) begin
            buf_q[pair_q]          <= cmp_hi;
            buf_q[pair_q + IW'(1)] <= cmp_lo;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != StLoad);
    assign swap_cnt      = swap_cnt_q;

endmodule

// File: tb/tb_fp_sort_ctrl.sv
// Directed bench for fp_sort_ctrl (DEPTH=8, CW=16): table of blocks with hand-sorted
// expectations, plus reset-abort sequences during SORT and OUT.
module tb_fp_sort_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] swap_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    fp_sort_ctrl_if bus ();

    fp_sort_ctrl #(
        .DEPTH (8),
        .CW    (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .swap_cnt (swap_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][31:0] din;
        logic [7:0][31:0] dout;
        logic             df;     // desc on first word
        logic             dr;     // desc on remaining words
        logic [15:0]      swaps;
        logic             bp;     // apply out_ready backpressure pattern
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0][31:0] pack8(
        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
        input logic [31:0] a3, input logic [31:0] a4, input logic [31:0] a5,
        input logic [31:0] a6, input logic [31:0] a7);
        logic [7:0][31:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),          32'd0);
        chk({tag, "_out_data"},  bus.out_data,       32'd0);
        chk({tag, "_swap_cnt"},  32'(swap_cnt),      32'd0);
    endtask

    // Feeds the 8 words; returns at the negedge just before the accepting edge of the last word.
    task automatic load_words(input vec_t v);
        int guard;
        bus.out_ready = 1'b1;  // must be ignored while out_valid=0
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = v.din[i];
            bus.desc     = (i == 0) ? v.df : v.dr;
            guard = 0;
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 100) chk("load_timeout", 32'(guard), 32'd0);
        end
    endtask

    // Keeps in_valid high with junk during SORT and measures edges until out_valid rises.
    task automatic wait_out();
        int   lat;
        logic ok;
        @(negedge clk);
        bus.in_data = 32'hDEAD_BEEF;
        bus.desc    = ~bus.desc;
        lat = 0;
        ok  = 1'b1;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready || !busy) ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'd50);
        chk("sort_in_ready_low_busy_high", 32'(ok), 32'd1);
    endtask

    task automatic drain(input vec_t v, input int nwords);
        int   k;
        int   cyc;
        logic rdy;
        logic [3:0] pat;
        pat = 4'b1001;  // cycle order 1,0,0,1 (bit 0 first)
        k   = 0;
        cyc = 0;
        while (k < nwords && cyc < 200) begin
            chk("out_valid", 32'(bus.out_valid), 32'd1);
            chk("out_data", bus.out_data, v.dout[k]);
            chk("out_last", 32'(bus.out_last), 32'(k == 7));
            chk("out_in_ready_low", 32'(bus.in_ready), 32'd0);
            rdy = v.bp ? pat[cyc % 4] : 1'b1;
            bus.out_ready = rdy;
            if (rdy) begin
                k++;
                if (k == 8) bus.in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 200) chk("drain_timeout", 32'(k), 32'(nwords));
        bus.out_ready = 1'b0;
        if (nwords == 8) begin
            chk("swap_cnt", 32'(swap_cnt), 32'(v.swaps));
            chk("post_out_valid", 32'(bus.out_valid), 32'd0);
            chk("post_out_last", 32'(bus.out_last), 32'd0);
            chk("post_busy", 32'(busy), 32'd0);
            chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        end
    endtask

    task automatic run_block(input vec_t v);
        load_words(v);
        wait_out();
        drain(v, 8);
    endtask

    task automatic abort_reset(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals(tag);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk({tag, "_in_ready_at_release"}, 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk({tag, "_in_ready_after_edge"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_busy_after_edge"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][31:0] a1, sa, sd, ties_in, ties_out, inf_in, inf_out;
        a1 = pack8(32'h40000000, 32'hBF800000, 32'h3F000000, 32'hC0000000,
                   32'h40400000, 32'h00000000, 32'h80000000, 32'h3F800000);
        sa = pack8(32'hC0000000, 32'hBF800000, 32'h80000000, 32'h00000000,
                   32'h3F000000, 32'h3F800000, 32'h40000000, 32'h40400000);
        sd = pack8(32'h40400000, 32'h40000000, 32'h3F800000, 32'h3F000000,
                   32'h00000000, 32'h80000000, 32'hBF800000, 32'hC0000000);
        ties_in  = pack8(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                         32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000);
        ties_out = pack8(32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000,
                         32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        inf_in  = pack8(32'h7F800000, 32'h40400000, 32'hFF800000, 32'h3F800000,
                        32'h00000000, 32'hBF800000, 32'h40000000, 32'hC0000000);
        inf_out = pack8(32'hFF800000, 32'hC0000000, 32'hBF800000, 32'h00000000,
                        32'h3F800000, 32'h40000000, 32'h40400000, 32'h7F800000);

        //                 din      dout      df    dr    swaps   bp
        vecs[0] = '{din: a1,      dout: sa,       df: 0, dr: 0, swaps: 16'd14, bp: 0};
        vecs[1] = '{din: sa,      dout: sa,       df: 0, dr: 0, swaps: 16'd0,  bp: 1};
        vecs[2] = '{din: sd,      dout: sa,       df: 0, dr: 0, swaps: 16'd28, bp: 0};
        vecs[3] = '{din: a1,      dout: sd,       df: 1, dr: 1, swaps: 16'd14, bp: 1};
        vecs[4] = '{din: a1,      dout: sa,       df: 0, dr: 1, swaps: 16'd14, bp: 0};
        vecs[5] = '{din: ties_in, dout: ties_out, df: 0, dr: 0, swaps: 16'd16, bp: 1};
        vecs[6] = '{din: inf_in,  dout: inf_out,  df: 0, dr: 0, swaps: 16'd20, bp: 0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.desc      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        #1 chk("release_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("first_edge_in_ready", 32'(bus.in_ready), 32'd1);

        for (int v = 0; v < 7; v++) begin
            run_block(vecs[v]);
        end

        // Abort during SORT, then a full block must still sort correctly.
        load_words(vecs[0]);
        repeat (20) @(negedge clk);
        chk("mid_sort_busy", 32'(busy), 32'd1);
        abort_reset("rst_sort");
        run_block(vecs[6]);

        // Abort after three output words.
        load_words(vecs[2]);
        wait_out();
        drain(vecs[2], 3);
        abort_reset("rst_out");
        repeat (5) @(negedge clk);
        chk("no_partial_after_reset", 32'(bus.out_valid), 32'd0);
        run_block(vecs[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_sort_ctrl.md
Name: fp_sort_ctrl

Overview:
- Sequencing controller that sorts a block of DEPTH IEEE 754 single-precision words using one shared magnitude/sign comparator.
- Three phases: LOAD (stream in), SORT (bubble passes, one compare-and-swap per cycle), OUT (stream out).
- Sits after the FP ALU result path and feeds ordered results to downstream consumers. Valid/ready on both sides.

Parameters:
- DEPTH, 8, number of words per block; legal range 2..64.
- CW, 16, width of swap_cnt.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts a word
- in_data  input  32  IEEE 754 single word
- desc  input  1  sort order, sampled with the first accepted word of a block: 0 = ascending, 1 = descending
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts
- out_data  output  32  sorted word
- out_last  output  1  high with the final word of the block
- busy  output  1  high in SORT or OUT
- swap_cnt  output  CW  swaps performed in the current/last block, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; all indices 0; in_ready=0; out_valid=0; out_last=0; busy=0; out_data=0; swap_cnt=0.
  - Buffer contents are don't-care.
- in_ready is registered. It goes to 1 on the first clk edge after rst_n deasserts.
- Ordering function gt(a,b):
  - Signs differ: result is 1 when a[31]=0.
  - Both positive: a[30:0] > b[30:0].
  - Both negative: a[30:0] < b[30:0].
  - Bit-identical operands: 0.
  - +0 > -0. NaN/Inf are ordered purely by bit pattern under these rules.
  - Never latch; defined for all inputs.
- LOAD:
  - in_ready=1. Handshake occurs on in_valid&in_ready; buf[wr_idx] <= in_data; wr_idx++.
  - On the first accept, latch desc and clear swap_cnt.
  - On the DEPTH-th accept, in_ready <= 0 and state <= SORT at the same edge.
- SORT:
  - pass p = 0..DEPTH-2, pair j = 0..DEPTH-2, one pair per cycle. Exactly (DEPTH-1)^2 cycles, no early exit.
  - Swap condition: asc uses gt(buf[j],buf[j+1]); desc uses gt(buf[j+1],buf[j]).
  - On a swap, exchange the pair and increment swap_cnt, saturating at 2^CW-1.
  - Equal keys never swap, so the sort is stable.
  - After the last pair: state <= OUT; out_valid <= 1; out_data <= buf[0]; out_last <= (DEPTH==1 impossible, so 0).
- Latency: out_valid rises exactly (DEPTH-1)^2+1 clk edges after the edge of the last input accept (50 for DEPTH=8).
- OUT:
  - out_data/out_valid/out_last are registered and held stable while out_valid&!out_ready.
  - On a handshake, advance rd_idx and present buf[rd_idx+1]. out_last=1 only while rd_idx=DEPTH-1.
  - Handshake on the last word: out_valid <= 0; out_last <= 0; state <= LOAD; in_ready <= 1 at the same edge. No bubble cycle beyond that edge.
- busy=1 exactly when state is SORT or OUT.
- in_valid is ignored outside LOAD. out_ready is ignored when out_valid=0.
- Reset mid-operation (any state) aborts the block. Nothing partial is ever emitted afterwards.
- swap_cnt holds its value from end of SORT until the next block's first accept.

Test Plan:
- Reset then asc load, desc=0: [40000000, BF800000, 3F000000, C0000000, 40400000, 00000000, 80000000, 3F800000] -> out [C0000000, BF800000, 80000000, 00000000, 3F000000, 3F800000, 40000000, 40400000]. out_valid rises 50 cycles after the last accept. out_last on the 8th word only. busy low afterwards, in_ready high.
- Already-ascending 8 distinct words -> identical order out, swap_cnt=0, latency still 50. Strictly descending 8 distinct words -> swap_cnt=28.
- desc=1 with the first vector -> reverse of the ascending result. Change desc mid-load -> no effect.
- Ties: [3F800000 x4, BF800000 x4] asc -> four BF800000 then four 3F800000. Inf 7F800000 sorts after 40400000; FF800000 sorts first.
- Backpressure: out_ready toggling 1,0,0,1 -> out_data/out_last stable while stalled, no word lost or duplicated. in_ready=0 throughout SORT/OUT even with in_valid=1.
- rst_n pulsed low during SORT (cycle 20) and during OUT (after 3 words) -> outputs return to reset values immediately. in_ready=1 one edge after release. The next full block sorts correctly.
